// File: rtl/iter_divider.sv
// iter_divider: 32-bit signed/unsigned radix-2 restoring divider, one quotient bit per cycle.
// Accepts a request in IDLE, iterates 32 cycles in CALC, then pulses done for one cycle in DONE.
module iter_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        is_signed,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    input  logic        cancel,
    output logic        busy,
    output logic        done,
    output logic [31:0] quotient,
    output logic [31:0] remainder
);

    localparam int unsigned W  = 32;
    localparam int unsigned CW = 6;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_next;
    logic           accept_c;
    logic           finish_c;

    logic [W-1:0]   rem_r;
    logic [W-1:0]   quo_r;
    logic [W-1:0]   dvsr_r;
    logic [W-1:0]   raw_dividend_r;
    logic           q_neg_r;
    logic           r_neg_r;
    logic           div_zero_r;
    logic [CW-1:0]  count_r;

    logic [W:0]     shifted_c;
    logic           ge_c;
    logic [W-1:0]   rem_step_c;
    logic [W-1:0]   quo_step_c;
    logic [W-1:0]   dividend_mag_c;
    logic [W-1:0]   divisor_mag_c;
    logic [W-1:0]   q_fix_c;
    logic [W-1:0]   r_fix_c;

    // Operand magnitudes taken at acceptance (abs only for signed ops).
    always_comb begin
        dividend_mag_c = (is_signed && dividend[W-1]) ? W'(-dividend) : dividend;
        divisor_mag_c  = (is_signed && divisor[W-1])  ? W'(-divisor)  : divisor;
    end

    // One restoring-division step plus sign fix-up of the step result.
    always_comb begin
        shifted_c  = {rem_r, quo_r[W-1]};
        ge_c       = (shifted_c >= {1'b0, dvsr_r});
        rem_step_c = ge_c ? W'(shifted_c - {1'b0, dvsr_r}) : shifted_c[W-1:0];
        quo_step_c = {quo_r[W-2:0], ge_c};
        q_fix_c    = div_zero_r ? '1 : (q_neg_r ? W'(-quo_step_c) : quo_step_c);
        r_fix_c    = div_zero_r ? raw_dividend_r : (r_neg_r ? W'(-rem_step_c) : rem_step_c);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; cancel wins over everything.
    always_comb begin
        state_next = state;
        accept_c   = 1'b0;
        finish_c   = 1'b0;
        case (state)
            S_IDLE: begin
                if (req_valid && !cancel) begin
                    state_next = S_CALC;
                    accept_c   = 1'b1;
                end
            end
            S_CALC: begin
                if (cancel) begin
                    state_next = S_IDLE;
                end else if (count_r == CW'(W - 1)) begin
                    state_next = S_DONE;
                    finish_c   = 1'b1;
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Iteration datapath: operand capture on accept, one shift/subtract per CALC cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rem_r          <= '0;
            quo_r          <= '0;
            dvsr_r         <= '0;
            raw_dividend_r <= '0;
            q_neg_r        <= 1'b0;
            r_neg_r        <= 1'b0;
            div_zero_r     <= 1'b0;
            count_r        <= '0;
        end else if (accept_c) begin
            rem_r          <= '0;
            quo_r          <= dividend_mag_c;
            dvsr_r         <= divisor_mag_c;
            raw_dividend_r <= dividend;
            q_neg_r        <= is_signed & (dividend[W-1] ^ divisor[W-1]);
            r_neg_r        <= is_signed & dividend[W-1];
            div_zero_r     <= (divisor == '0);
            count_r        <= '0;
        end else if (state == S_CALC) begin
            rem_r          <= rem_step_c;
            quo_r          <= quo_step_c;
            count_r        <= count_r + CW'(1);
        end
    end

    // Registered outputs; results load only on the edge entering DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else begin
            busy <= (state_next != S_IDLE);
            done <= (state_next == S_DONE);
            if (finish_c) begin
                quotient  <= q_fix_c;
                remainder <= r_fix_c;
            end
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// tb_iter_divider: directed vectors for iter_divider, checked against a cycle-schedule model
// (plain-arithmetic division, done scheduled 33 cycles after acceptance) every cycle.
module tb_iter_divider;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        cancel;
    logic        busy;
    logic        done;
    logic [31:0] quotient;
    logic [31:0] remainder;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    logic chk_en = 1'b0;

    // Model state
    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic [31:0] m_q = '0;
    logic [31:0] m_r = '0;
    logic [31:0] p_q = '0;
    logic [31:0] p_r = '0;
    int          m_end = 0;
    logic [31:0] t_q;
    logic [31:0] t_r;

    iter_divider dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .cancel    (cancel),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic for one division.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        sa = $signed(a);
        sb = $signed(b);
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (!s) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'd0;
        end else begin
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    // Cycle-schedule model: result appears 33 cycles after acceptance unless cancelled/reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_q    <= '0;
            m_r    <= '0;
        end else if (cancel) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else if (!m_busy && req_valid) begin
            ref_div(dividend, divisor, is_signed, t_q, t_r);
            p_q    <= t_q;
            p_r    <= t_r;
            m_busy <= 1'b1;
            m_end  <= cyc + 33;
            m_done <= 1'b0;
        end else if (m_busy && cyc + 1 == m_end) begin
            m_done <= 1'b1;
            m_q    <= p_q;
            m_r    <= p_r;
        end else if (m_busy && cyc == m_end) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
        end else begin
            m_done <= 1'b0;
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("done", {31'd0, done}, {31'd0, m_done});
            chk("quotient", quotient, m_q);
            chk("remainder", remainder, m_r);
        end
    end

    // Issue one request, wait for done, check latency and literal results.
    task automatic run_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input logic [31:0] eq, input logic [31:0] er);
        int t0;
        logic [31:0] mq;
        logic [31:0] mr;
        ref_div(a, b, s, mq, mr);
        chk({nm, "_model_q"}, mq, eq);
        chk({nm, "_model_r"}, mr, er);
        @(negedge clk);
        dividend  = a;
        divisor   = b;
        is_signed = s;
        req_valid = 1'b1;
        t0 = cyc;
        @(negedge clk);
        chk({nm, "_busy_t1"}, {31'd0, busy}, 32'd1);
        for (int k = 0; k < 40; k++) begin
            if (done) break;
            @(negedge clk);
        end
        chk({nm, "_latency"}, 32'(cyc - t0), 32'd33);
        chk({nm, "_q"}, quotient, eq);
        chk({nm, "_r"}, remainder, er);
        req_valid = 1'b0;
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int k = 0; k < 45; k++) begin
            @(negedge clk);
            if (done) begin
                at = cyc;
                break;
            end
        end
    endtask

    initial begin
        int t0;
        int at;
        int seen;
        logic [31:0] prev_q;
        logic [31:0] prev_r;
        reset     = 1'b0;
        req_valid = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        cancel    = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_q", quotient, 32'd0);
        chk("rst_r", remainder, 32'd0);
        reset = 1'b1;

        run_op("u100_7",   32'd100,        32'd7,          1'b0, 32'd14,         32'd2);
        run_op("s-7_2",    32'hFFFF_FFF9,  32'd2,          1'b1, 32'hFFFF_FFFD,  32'hFFFF_FFFF);
        run_op("s7_-2",    32'd7,          32'hFFFF_FFFE,  1'b1, 32'hFFFF_FFFD,  32'd1);
        run_op("s-7_-2",   32'hFFFF_FFF9,  32'hFFFF_FFFE,  1'b1, 32'd3,          32'hFFFF_FFFF);
        run_op("uFFF9_2",  32'hFFFF_FFF9,  32'd2,          1'b0, 32'h7FFF_FFFC,  32'd1);
        run_op("sdiv0",    32'h1234_5678,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h1234_5678);
        run_op("udiv0",    32'h1234_5678,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h1234_5678);
        run_op("sovf",     32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 32'h8000_0000,  32'd0);
        run_op("umax",     32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0);
        run_op("sneg_div0",32'h8000_0000,  32'd0,          1'b1, 32'hFFFF_FFFF,  32'h8000_0000);

        // Cancel mid-operation, then a new request right after.
        prev_q = quotient;
        prev_r = remainder;
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd3;
        is_signed = 1'b0;
        req_valid = 1'b1;
        t0 = cyc;
        repeat (10) @(negedge clk);
        cancel   = 1'b1;
        dividend = 32'd50;
        divisor  = 32'd5;
        @(negedge clk);
        cancel = 1'b0;
        chk("cancel_busy", {31'd0, busy}, 32'd0);
        chk("cancel_q_held", quotient, prev_q);
        chk("cancel_r_held", remainder, prev_r);
        wait_done(at);
        chk("cancel_relat", 32'(at - t0), 32'd44);
        chk("cancel_req_q", quotient, 32'd10);
        chk("cancel_req_r", remainder, 32'd0);
        req_valid = 1'b0;

        // Back-to-back with req_valid held high.
        @(negedge clk);
        dividend  = 32'd1000;
        divisor   = 32'd3;
        req_valid = 1'b1;
        t0 = cyc;
        wait_done(at);
        chk("b2b_lat1", 32'(at - t0), 32'd33);
        chk("b2b_q1", quotient, 32'd333);
        chk("b2b_r1", remainder, 32'd1);
        dividend = 32'd50;
        divisor  = 32'd5;
        wait_done(at);
        chk("b2b_lat2", 32'(at - t0), 32'd67);
        chk("b2b_q2", quotient, 32'd10);
        chk("b2b_r2", remainder, 32'd0);
        req_valid = 1'b0;

        // Reset in the middle of an operation.
        @(negedge clk);
        dividend  = 32'd100;
        divisor   = 32'd7;
        req_valid = 1'b1;
        t0 = cyc;
        repeat (20) @(negedge clk);
        reset     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mrst_busy", {31'd0, busy}, 32'd0);
        chk("mrst_done", {31'd0, done}, 32'd0);
        chk("mrst_q", quotient, 32'd0);
        chk("mrst_r", remainder, 32'd0);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("mrst_no_done", 32'(seen), 32'd0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/iter_divider.md
# iter_divider

Multi-cycle 32-bit integer divider that serves the EXE stage's DIV/MOD requests (signed and unsigned). EXE holds a request while its instruction is valid and stalls until this block pulses `done`. The block computes quotient and remainder with a radix-2 restoring algorithm, one bit per cycle. Results are registered and held until the next completion.

## Interface
No parameters; data width is fixed at 32.
- clk  input  1  clock; all state changes on rising edge
- reset  input  1  synchronous, active-low reset (0 = reset)
- req_valid  input  1  request present; held high by EXE until `done`
- is_signed  input  1  1 = signed (div.w/mod.w), 0 = unsigned (div.wu/mod.wu)
- dividend  input  32  numerator, sampled only on acceptance
- divisor  input  32  denominator, sampled only on acceptance
- cancel  input  1  pipeline flush; aborts any operation
- busy  output  1  1 while an accepted operation is in flight (CALC or DONE)
- done  output  1  one-cycle pulse; quotient/remainder valid from this cycle
- quotient  output  32  result quotient, held until next `done`
- remainder  output  32  result remainder, held until next `done`

## Operation
- States: IDLE, CALC, DONE.
- IDLE: if `req_valid && !cancel`, accept:
  - latch `|dividend|` and `|divisor|` (abs only when `is_signed`);
  - latch q_neg = is_signed & (dividend[31]^divisor[31]), r_neg = is_signed & dividend[31];
  - latch div_zero = (divisor==0) and the raw dividend;
  - clear the 6-bit count; go to CALC.
- CALC: each cycle shift {rem33, q32} left by one bit and trial-subtract the divisor magnitude from the 33-bit partial remainder. If the result is non-negative, keep it and set quotient LSB=1; otherwise restore and set LSB=0. Increment count. After the 32nd iteration (count==31), go to DONE.
  - On that same edge load the `quotient`/`remainder` output registers with the sign-fixed result: negate q if q_neg, negate r if r_neg.
- DONE: `done`=1 for exactly this cycle; return to IDLE unconditionally.
- Special cases:
  - Divide by zero: quotient=0xFFFFFFFF, remainder=raw dividend, for both signed and unsigned.
  - Signed overflow 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0. Falls out of 32-bit unsigned magnitudes plus negation; no special case needed.
- Inputs other than `req_valid`/`cancel` are ignored outside IDLE.
- `cancel`=1 in any state: go to IDLE next edge. No `done` is produced; output registers are not updated. `cancel` beats acceptance in IDLE.
- `busy` = (state != IDLE).

## Timing
- Reset (`reset`=0 at an edge): state IDLE; busy=0, done=0, quotient=0, remainder=0. Any in-flight operation is discarded, with no `done`.
- Acceptance edge E0 occurs at the end of cycle T, where T is the first IDLE cycle with req_valid=1.
- CALC occupies cycles T+1..T+32. `done`=1 in cycle T+33. IDLE in cycle T+34. Fixed latency is 33 cycles from request to `done`, independent of operand values.
- EXE advances on the edge ending cycle T+33. If `req_valid` is still 1 in T+34, that is treated as a new request: it is accepted at the end of T+34, and its `done` comes in T+67.
- `quotient`/`remainder` change only on the edge entering DONE.

## Test plan
- Unsigned: req at T with 100 / 7, is_signed=0 -> done=1 only in T+33; quotient=14, remainder=2; busy=1 during T+1..T+33.
- Signed sign rules: -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF; 7/-2 -> q=0xFFFFFFFD, r=1; -7/-2 -> q=3, r=0xFFFFFFFF. Unsigned 0xFFFFFFF9/2 -> q=0x7FFFFFFC, r=1.
- Corners: 0x12345678/0 (signed and unsigned) -> q=0xFFFFFFFF, r=0x12345678. Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
- Cancel: accept at T; cancel=1 in T+10 -> busy=0 in T+11, no done ever, outputs keep their previous values. A request in T+11 is accepted, and its done comes in T+44.
- Back-to-back: req_valid held high; operands change to 50/5 in T+34 -> first done in T+33 (first result), second done in T+67 with q=10, r=0.
- Reset mid-op: reset=0 during T+20 -> in T+21 busy=0, done=0, quotient=0, remainder=0. No done at T+33.
